// File: rtl/uart_rx_fifo.sv
// Receive buffer behind uart_rx: first-word-fall-through byte FIFO with sticky
// error status and an empty->non-empty interrupt pulse.
module uart_rx_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  input  logic                  overrun_in,
  input  logic                  frame_in,
  input  logic                  flush,
  input  logic                  clear_status,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  full,
  output logic                  overrun_sticky,
  output logic                  frame_sticky,
  output logic                  irq
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] CNT_FULL = (DEPTH_LOG2+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr, r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic                  r_irq, r_ovr, r_frm;
  logic                  w_push, w_pop, w_full, w_empty;

  assign w_full  = (r_count == CNT_FULL);
  assign w_empty = (r_count == '0);
  // tready comes from pre-edge state only, so a same-cycle pop never opens a slot
  assign w_push  = s_axis_tvalid & ~w_full;
  assign w_pop   = ~w_empty & m_axis_tready;

  always_ff @(posedge clk) begin
    if (rst_n && w_push && !flush) r_mem[r_wr_ptr] <= s_axis_tdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_irq    <= 1'b0;
      r_ovr    <= 1'b0;
      r_frm    <= 1'b0;
    end else begin
      if (flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + 1'b1;
          2'b01:   r_count <= r_count - 1'b1;
          default: r_count <= r_count;
        endcase
      end
      r_irq <= w_push & w_empty & ~flush;
      // set beats clear when both arrive together
      r_ovr <= overrun_in | (r_ovr & ~clear_status);
      r_frm <= frame_in   | (r_frm & ~clear_status);
    end
  end

  assign s_axis_tready  = ~w_full;
  assign m_axis_tvalid  = ~w_empty;
  assign m_axis_tdata   = r_mem[r_rd_ptr];
  assign count          = r_count;
  assign full           = w_full;
  assign overrun_sticky = r_ovr;
  assign frame_sticky   = r_frm;
  assign irq            = r_irq;
endmodule
